// File: rtl/rob_client_arb.sv
// Shares one ROB request/response port pair between NREQ clients.
// Round-robin request arbitration; in-order responses are steered back by a tag FIFO.
module rob_client_arb #(
  parameter int NREQ    = 4,
  parameter int NWIDTH  = 2,
  parameter int AWIDTH  = 40,
  parameter int DWIDTH  = 32,
  parameter int PWIDTH  = 32,
  parameter int IDWIDTH = 16,
  parameter int DEPTH   = 16,
  parameter int DPTR    = 4,
  parameter int MAX_OUT = 8,
  parameter int CWIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [NREQ-1:0]         c_req_val,
  input  logic [NREQ*AWIDTH-1:0]  c_req_addr,
  input  logic [NREQ*IDWIDTH-1:0] c_req_ID,
  input  logic [NREQ*PWIDTH-1:0]  c_req_param,
  output logic [NREQ-1:0]         c_req_ready,
  output logic [NREQ-1:0]         c_rsp_val,
  output logic [DWIDTH-1:0]       c_rsp_data,
  output logic [IDWIDTH-1:0]      c_rsp_ID,
  output logic [PWIDTH-1:0]       c_rsp_param,
  input  logic [NREQ-1:0]         c_rsp_ready,
  output logic                    rob_req_val,
  output logic [AWIDTH-1:0]       rob_req_addr,
  output logic [IDWIDTH-1:0]      rob_req_ID,
  output logic [PWIDTH-1:0]       rob_req_param,
  input  logic                    rob_req_ready,
  input  logic                    rob_rsp_val,
  input  logic [DWIDTH-1:0]       rob_rsp_data,
  input  logic [IDWIDTH-1:0]      rob_rsp_ID,
  input  logic [PWIDTH-1:0]       rob_rsp_param,
  output logic                    rob_rsp_ready,
  output logic                    err_orphan,
  output logic [DPTR:0]           tag_cnt
);

  logic [NWIDTH-1:0] rr_pnt_r;
  logic [CWIDTH-1:0] out_cnt_r [NREQ];
  logic [NWIDTH-1:0] tag_mem_r [DEPTH];
  logic [DPTR-1:0]   wr_ptr_r;
  logic [DPTR-1:0]   rd_ptr_r;
  logic [DPTR:0]     tag_cnt_r;
  logic              err_orphan_r;

  logic [NREQ-1:0]   eligible_s;
  logic [NREQ-1:0]   gnt_s;
  logic [NREQ-1:0]   inc_s;
  logic [NREQ-1:0]   dec_s;
  logic [NWIDTH-1:0] gnt_idx_s;
  logic [NWIDTH-1:0] scan_idx_s;
  logic [NWIDTH-1:0] head_s;
  logic              found_s;
  logic              full_s;
  logic              empty_s;
  logic              req_hs_s;
  logic              rsp_hs_s;

  assign full_s   = (tag_cnt_r == (DPTR+1)'(DEPTH));
  assign empty_s  = (tag_cnt_r == {(DPTR+1){1'b0}});
  assign head_s   = tag_mem_r[rd_ptr_r];
  assign req_hs_s = rob_req_val & rob_req_ready;
  assign rsp_hs_s = rob_rsp_val & rob_rsp_ready;

  // Per-client eligibility and outstanding-counter update strobes
  always_comb begin
    eligible_s = {NREQ{1'b0}};
    inc_s      = {NREQ{1'b0}};
    dec_s      = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      eligible_s[i] = c_req_val[i] & (out_cnt_r[i] != CWIDTH'(MAX_OUT));
      inc_s[i]      = req_hs_s & (gnt_idx_s == NWIDTH'(i));
      dec_s[i]      = rsp_hs_s & (head_s == NWIDTH'(i));
    end
  end

  // Round-robin scan: first eligible client at or after rr_pnt, wrapping
  always_comb begin
    found_s    = 1'b0;
    gnt_idx_s  = {NWIDTH{1'b0}};
    scan_idx_s = {NWIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s = rr_pnt_r + NWIDTH'(k);
      if (!found_s && eligible_s[scan_idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = scan_idx_s;
      end else begin
        found_s   = found_s;
      end
    end
    if (found_s) begin
      gnt_s = NREQ'(1) << gnt_idx_s;
    end else begin
      gnt_s = {NREQ{1'b0}};
    end
  end

  // Request outputs are forced idle while reset is asserted
  assign rob_req_val   = rst_ & found_s & ~full_s;
  assign c_req_ready   = rst_ ? (gnt_s & {NREQ{~full_s & rob_req_ready}}) : {NREQ{1'b0}};
  assign rob_req_addr  = c_req_addr[gnt_idx_s*AWIDTH +: AWIDTH];
  assign rob_req_ID    = c_req_ID[gnt_idx_s*IDWIDTH +: IDWIDTH];
  assign rob_req_param = c_req_param[gnt_idx_s*PWIDTH +: PWIDTH];

  // Steer the response valid to the client recorded at the FIFO head
  always_comb begin
    c_rsp_val = {NREQ{1'b0}};
    if (rob_rsp_val && !empty_s) begin
      c_rsp_val[head_s] = 1'b1;
    end else begin
      c_rsp_val = {NREQ{1'b0}};
    end
  end

  assign rob_rsp_ready = ~empty_s & c_rsp_ready[head_s];
  assign c_rsp_data    = rob_rsp_data;
  assign c_rsp_ID      = rob_rsp_ID;
  assign c_rsp_param   = rob_rsp_param;
  assign err_orphan    = err_orphan_r;
  assign tag_cnt       = tag_cnt_r;

  // Tag FIFO, round-robin pointer and sticky orphan flag
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int d = 0; d < DEPTH; d++) begin
        tag_mem_r[d] <= {NWIDTH{1'b0}};
      end
      wr_ptr_r     <= {DPTR{1'b0}};
      rd_ptr_r     <= {DPTR{1'b0}};
      tag_cnt_r    <= {(DPTR+1){1'b0}};
      rr_pnt_r     <= {NWIDTH{1'b0}};
      err_orphan_r <= 1'b0;
    end else begin
      if (req_hs_s) begin
        tag_mem_r[wr_ptr_r] <= gnt_idx_s;
        wr_ptr_r            <= wr_ptr_r + 1'b1;
        rr_pnt_r            <= gnt_idx_s + 1'b1;
      end
      if (rsp_hs_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({req_hs_s, rsp_hs_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + 1'b1;
        2'b01:   tag_cnt_r <= tag_cnt_r - 1'b1;
        default: tag_cnt_r <= tag_cnt_r;
      endcase
      err_orphan_r <= err_orphan_r | (rob_rsp_val & empty_s);
    end
  end

  // Per-client outstanding counters
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < NREQ; i++) begin
        out_cnt_r[i] <= {CWIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   out_cnt_r[i] <= out_cnt_r[i] + 1'b1;
          2'b01:   out_cnt_r[i] <= out_cnt_r[i] - 1'b1;
          default: out_cnt_r[i] <= out_cnt_r[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_client_arb.sv
// Self-checking bench for rob_client_arb: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rob_client_arb;

  logic         clk;
  logic         rst_;
  logic [3:0]   c_req_val;
  logic [159:0] c_req_addr;
  logic [63:0]  c_req_ID;
  logic [127:0] c_req_param;
  logic [3:0]   c_req_ready;
  logic [3:0]   c_rsp_val;
  logic [31:0]  c_rsp_data;
  logic [15:0]  c_rsp_ID;
  logic [31:0]  c_rsp_param;
  logic [3:0]   c_rsp_ready;
  logic         rob_req_val;
  logic [39:0]  rob_req_addr;
  logic [15:0]  rob_req_ID;
  logic [31:0]  rob_req_param;
  logic         rob_req_ready;
  logic         rob_rsp_val;
  logic [31:0]  rob_rsp_data;
  logic [15:0]  rob_rsp_ID;
  logic [31:0]  rob_rsp_param;
  logic         rob_rsp_ready;
  logic         err_orphan;
  logic [4:0]   tag_cnt;

  rob_client_arb dut (
    .clk(clk), .rst_(rst_),
    .c_req_val(c_req_val), .c_req_addr(c_req_addr), .c_req_ID(c_req_ID),
    .c_req_param(c_req_param), .c_req_ready(c_req_ready),
    .c_rsp_val(c_rsp_val), .c_rsp_data(c_rsp_data), .c_rsp_ID(c_rsp_ID),
    .c_rsp_param(c_rsp_param), .c_rsp_ready(c_rsp_ready),
    .rob_req_val(rob_req_val), .rob_req_addr(rob_req_addr), .rob_req_ID(rob_req_ID),
    .rob_req_param(rob_req_param), .rob_req_ready(rob_req_ready),
    .rob_rsp_val(rob_rsp_val), .rob_rsp_data(rob_rsp_data), .rob_rsp_ID(rob_rsp_ID),
    .rob_rsp_param(rob_rsp_param), .rob_rsp_ready(rob_rsp_ready),
    .err_orphan(err_orphan), .tag_cnt(tag_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] cid [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_cl
    assign c_req_addr[gi*40 +: 40]  = {8'(gi), 16'h0000, cid[gi]};
    assign c_req_ID[gi*16 +: 16]    = cid[gi];
    assign c_req_param[gi*32 +: 32] = {16'(gi + 16'h00A0), cid[gi]};
  end

  // ROB stub state and logs of observed handshakes
  logic [47:0] rob_q [$];
  int          grants [$];
  logic [19:0] rsp_log [$];
  bit          rsp_en;
  bit          force_orphan;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  mq [$];
  int  mcnt [4];
  int  mrr;
  bit  merr;
  bit  m_full, m_empty, m_any, e_rqv, e_rrdy;
  int  m_g, m_c, m_head;
  logic [3:0] e_rdy, e_cval;

  always @(negedge clk) begin : cmp
    if (!rst_) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
      mrr  = 0;
      merr = 1'b0;
    end
    m_full  = (mq.size() == 16);
    m_empty = (mq.size() == 0);
    m_any   = 1'b0;
    m_g     = 0;
    for (int k = 0; k < 4; k++) begin
      m_c = (mrr + k) % 4;
      if (!m_any && c_req_val[m_c] && mcnt[m_c] != 8) begin
        m_any = 1'b1;
        m_g   = m_c;
      end
    end
    e_rqv  = rst_ && m_any && !m_full;
    e_rdy  = (e_rqv && rob_req_ready) ? 4'(1 << m_g) : 4'b0000;
    m_head = m_empty ? 0 : mq[0];
    e_cval = (rob_rsp_val && !m_empty) ? 4'(1 << m_head) : 4'b0000;
    e_rrdy = !m_empty && c_rsp_ready[m_head];

    chk("m_c_req_ready", 64'(c_req_ready), 64'(e_rdy));
    chk("m_rob_req_val", 64'(rob_req_val), 64'(e_rqv));
    if (e_rqv) begin
      chk("m_rob_req_addr", 64'(rob_req_addr), 64'(c_req_addr[m_g*40 +: 40]));
      chk("m_rob_req_ID", 64'(rob_req_ID), 64'(c_req_ID[m_g*16 +: 16]));
      chk("m_rob_req_param", 64'(rob_req_param), 64'(c_req_param[m_g*32 +: 32]));
    end
    chk("m_c_rsp_val", 64'(c_rsp_val), 64'(e_cval));
    chk("m_rob_rsp_ready", 64'(rob_rsp_ready), 64'(e_rrdy));
    if (e_cval != 4'b0000) begin
      chk("m_c_rsp_data", 64'(c_rsp_data), 64'(rob_rsp_data));
      chk("m_c_rsp_ID", 64'(c_rsp_ID), 64'(rob_rsp_ID));
      chk("m_c_rsp_param", 64'(c_rsp_param), 64'(rob_rsp_param));
    end
    chk("m_tag_cnt", 64'(tag_cnt), 64'(mq.size()));
    chk("m_err_orphan", 64'(err_orphan), 64'(merr));

    if (rst_) begin
      if (rob_rsp_val && m_empty) merr = 1'b1;
      if (rob_rsp_val && e_rrdy) begin
        mcnt[m_head]--;
        void'(mq.pop_front());
      end
      if (e_rqv && rob_req_ready) begin
        mq.push_back(m_g);
        mcnt[m_g]++;
        mrr = (m_g + 1) % 4;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_rob();
    if (rob_q.size() != 0) begin
      rob_rsp_ID    = rob_q[0][15:0];
      rob_rsp_param = rob_q[0][47:16];
      rob_rsp_data  = 32'hD000_0000 | 32'(rob_q[0][15:0]);
    end else begin
      rob_rsp_ID    = 16'h0000;
      rob_rsp_param = 32'h0000_0000;
      rob_rsp_data  = 32'hDEAD_BEEF;
    end
    rob_rsp_val = force_orphan | (rsp_en & (rob_q.size() != 0));
  endtask

  task automatic step();
    logic [3:0]  hs;
    logic        rhs, rsphs;
    logic [47:0] ent;
    logic [19:0] lg;
    @(negedge clk);
    hs    = c_req_val & c_req_ready;
    rhs   = rob_req_val & rob_req_ready;
    rsphs = rob_rsp_val & rob_rsp_ready;
    ent   = {rob_req_param, rob_req_ID};
    lg    = {4'hF, c_rsp_ID};
    for (int i = 0; i < 4; i++) if (c_rsp_val[i]) lg[19:16] = 4'(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        cid[i] = cid[i] + 16'd1;
        grants.push_back(i);
      end
    end
    if (rsphs) begin
      void'(rob_q.pop_front());
      rsp_log.push_back(lg);
    end
    if (rhs) rob_q.push_back(ent);
    drive_rob();
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    c_req_val = 4'b0000;
    c_rsp_ready = 4'b1111;
    rob_req_ready = 1'b1;
    rsp_en = 1'b0;
    force_orphan = 1'b0;
    for (int i = 0; i < 4; i++) cid[i] = 16'd0;
    rob_q.delete();
    grants.delete();
    rsp_log.delete();
    drive_rob();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_ = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d0;
  int exp2 [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0;
    c_req_val = 4'b0000;
    c_rsp_ready = 4'b1111;
    rob_req_ready = 1'b1;
    rsp_en = 1'b0;
    force_orphan = 1'b0;
    for (int i = 0; i < 4; i++) cid[i] = 16'd0;
    drive_rob();
    #2;
    chk("rst_c_req_ready", 64'(c_req_ready), 64'(0));
    chk("rst_rob_req_val", 64'(rob_req_val), 64'(0));
    chk("rst_tag_cnt", 64'(tag_cnt), 64'(0));
    chk("rst_err_orphan", 64'(err_orphan), 64'(0));
    do_reset();

    // 1: client 2 alone, five back-to-back requests then five in-order responses
    c_req_val = 4'b0100;
    for (int n = 0; n < 20 && grants.size() < 5; n++) step();
    c_req_val = 4'b0000;
    chk("t1_grant_count", 64'(grants.size()), 64'(5));
    for (int k = 0; k < grants.size() && k < 5; k++) chk("t1_grant_client", 64'(grants[k]), 64'(2));
    chk("t1_tag_cnt_5", 64'(tag_cnt), 64'(5));
    rsp_en = 1'b1;
    drive_rob();
    for (int n = 0; n < 20 && rsp_log.size() < 5; n++) step();
    chk("t1_rsp_count", 64'(rsp_log.size()), 64'(5));
    for (int k = 0; k < rsp_log.size() && k < 5; k++) begin
      chk("t1_rsp_client", 64'(rsp_log[k][19:16]), 64'(2));
      chk("t1_rsp_id", 64'(rsp_log[k][15:0]), 64'(k));
    end
    chk("t1_tag_cnt_0", 64'(tag_cnt), 64'(0));

    // 2: all clients valid from rr_pnt=0
    do_reset();
    c_req_val = 4'b1111;
    repeat (6) step();
    c_req_val = 4'b0000;
    chk("t2_grant_count", 64'(grants.size()), 64'(6));
    for (int k = 0; k < grants.size() && k < 6; k++) chk("t2_grant_order", 64'(grants[k]), 64'(exp2[k]));

    // 3: client 0 reaches MAX_OUT, client 1 unaffected, one response re-enables client 0
    do_reset();
    c_req_val = 4'b0001;
    for (int n = 0; n < 20 && grants.size() < 8; n++) step();
    chk("t3_grant_count", 64'(grants.size()), 64'(8));
    #1;
    chk("t3_c0_blocked", 64'(c_req_ready[0]), 64'(0));
    chk("t3_req_val_idle", 64'(rob_req_val), 64'(0));
    c_req_val = 4'b0011;
    #1;
    chk("t3_c1_granted", 64'(c_req_ready), 64'(4'b0010));
    c_req_val = 4'b0001;
    rsp_en = 1'b1;
    drive_rob();
    #1;
    chk("t3_c0_blocked_same_cycle", 64'(c_req_ready[0]), 64'(0));
    step();
    rsp_en = 1'b0;
    drive_rob();
    #1;
    chk("t3_c0_eligible_again", 64'(c_req_ready[0]), 64'(1));
    c_req_val = 4'b0000;

    // 4: fill the tag FIFO, then pop while a push is pending
    do_reset();
    c_req_val = 4'b1111;
    for (int n = 0; n < 40 && grants.size() < 16; n++) step();
    #1;
    chk("t4_tag_cnt_full", 64'(tag_cnt), 64'(16));
    chk("t4_req_val_full", 64'(rob_req_val), 64'(0));
    rsp_en = 1'b1;
    drive_rob();
    #1;
    chk("t4_push_blocked", 64'(c_req_ready), 64'(0));
    step();
    rsp_en = 1'b0;
    drive_rob();
    chk("t4_tag_cnt_15", 64'(tag_cnt), 64'(15));
    step();
    chk("t4_tag_cnt_16", 64'(tag_cnt), 64'(16));
    c_req_val = 4'b0000;

    // 5: head belongs to client 3, which stalls its response
    do_reset();
    c_req_val = 4'b1000;
    for (int n = 0; n < 10 && grants.size() < 1; n++) step();
    c_req_val = 4'b0000;
    c_rsp_ready = 4'b0111;
    rsp_en = 1'b1;
    drive_rob();
    #1;
    chk("t5_rob_rsp_ready", 64'(rob_rsp_ready), 64'(0));
    chk("t5_c_rsp_val", 64'(c_rsp_val), 64'(4'b1000));
    d0 = c_rsp_data;
    step();
    chk("t5_data_held", 64'(c_rsp_data), 64'(d0));
    chk("t5_tag_cnt_held", 64'(tag_cnt), 64'(1));
    c_rsp_ready = 4'b1111;
    step();
    rsp_en = 1'b0;
    drive_rob();
    chk("t5_tag_cnt_drained", 64'(tag_cnt), 64'(0));

    // 6: orphan response, then reset in the middle of traffic
    force_orphan = 1'b1;
    drive_rob();
    #1;
    chk("t6_orphan_not_yet", 64'(err_orphan), 64'(0));
    step();
    chk("t6_orphan_set", 64'(err_orphan), 64'(1));
    force_orphan = 1'b0;
    drive_rob();
    step();
    chk("t6_orphan_sticky", 64'(err_orphan), 64'(1));
    c_req_val = 4'b1111;
    step();
    step();
    chk("t6_tag_cnt_pre_rst", 64'(tag_cnt), 64'(2));
    rst_ = 1'b0;
    #1;
    chk("t6_rst_tag_cnt", 64'(tag_cnt), 64'(0));
    chk("t6_rst_err_orphan", 64'(err_orphan), 64'(0));
    chk("t6_rst_c_req_ready", 64'(c_req_ready), 64'(0));
    chk("t6_rst_rob_req_val", 64'(rob_req_val), 64'(0));
    do_reset();
    c_req_val = 4'b0001;
    for (int n = 0; n < 20 && grants.size() < 8; n++) step();
    c_req_val = 4'b0000;
    chk("t6_post_rst_c0_full_quota", 64'(grants.size()), 64'(8));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
